// File: rtl/seqlock_pkg.sv
// Shared definitions for the colour-sequence lock session controller.
package seqlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_UNLOCK  = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    localparam int DEF_CODE_LEN    = 4;
    localparam int DEF_TIMEOUT_CYC = 1000;
    localparam int DEF_UNLOCK_CYC  = 50;
    localparam int DEF_LOCKOUT_CYC = 5000;
    localparam int DEF_MAX_FAIL    = 3;

    // Largest of three durations; sizes the shared down-counter.
    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/seqlock_ctrl_btn_sync.sv
// Raw button conditioning: 2-flop synchroniser followed by a registered
// rising-edge detector. A held button yields one pulse; re-arming needs a
// low level to pass through the synchroniser.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    // Next-state of the synchroniser chain and the edge pulse.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    // Synchroniser and edge-detector registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/seqlock_ctrl.sv
// Session controller for the colour-sequence detector: conditions buttons,
// drives detector start/accept/clear, judges attempts, and enforces the
// inactivity timeout and the lockout period.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; accept ignored
//   ARMED   | collecting accepts; idle timer running
//   CHECK   | one cycle, sample detector match
//   UNLOCK  | unlock held for UNLOCK_CYC cycles
//   FAIL    | one cycle, clear detector and count the failure
//   LOCKOUT | locked held for LOCKOUT_CYC cycles; buttons ignored
module seqlock_ctrl
    import seqlock_pkg::*;
#(
    parameter int CODE_LEN    = DEF_CODE_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int MAX_FAIL    = DEF_MAX_FAIL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s,
    input  logic       a,
    input  logic       det_u,
    output logic       det_s,
    output logic       det_a,
    output logic       det_clr,
    output logic       unlock,
    output logic       locked,
    output logic [1:0] fail_cnt,
    output logic       busy
);

    localparam int TMR_W = $clog2(max3(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC) + 1);
    localparam int ACC_W = $clog2(CODE_LEN + 1);

    localparam logic [TMR_W-1:0] T_IDLE   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] T_UNLOCK = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(CODE_LEN);
    localparam logic [1:0]       FAIL_LIM = 2'(MAX_FAIL);

    logic s_p, a_p;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [1:0]       fail_cnt_q, fail_cnt_d;
    logic             first_q, first_d;
    logic             det_s_q, det_s_d;
    logic             det_a_q, det_a_d;
    logic             det_clr_q, det_clr_d;
    logic             unlock_q, unlock_d;
    logic             locked_q, locked_d;
    logic             busy_q, busy_d;
    logic [1:0]       fail_next;

    btn_sync u_s_sync (.clk(clk), .rst(rst), .btn(s), .pulse(s_p));
    btn_sync u_a_sync (.clk(clk), .rst(rst), .btn(a), .pulse(a_p));

    // Next-state, shared timer, counters and registered output values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        acc_cnt_d  = acc_cnt_q;
        fail_cnt_d = fail_cnt_q;
        first_d    = 1'b0;
        det_s_d    = 1'b0;
        det_a_d    = 1'b0;
        // Keep the detector clear through the first edge after reset release.
        det_clr_d  = first_q;
        unlock_d   = 1'b0;
        locked_d   = 1'b0;
        fail_next  = (fail_cnt_q == 2'd3) ? fail_cnt_q : fail_cnt_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (s_p) begin
                    det_s_d   = 1'b1;
                    acc_cnt_d = '0;
                    timer_d   = T_IDLE;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // CHECK follows one cycle after the last det_a pulse so the
                // detector has registered its final state before det_u is read.
                if (acc_cnt_q == ACC_LAST) begin
                    state_d = ST_CHECK;
                end else if (a_p) begin
                    det_a_d   = 1'b1;
                    acc_cnt_d = acc_cnt_q + ACC_W'(1);
                    timer_d   = T_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CHECK: begin
                if (det_u) begin
                    unlock_d   = 1'b1;
                    fail_cnt_d = '0;
                    timer_d    = T_UNLOCK;
                    state_d    = ST_UNLOCK;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_UNLOCK: begin
                if (timer_q == '0) begin
                    det_clr_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    unlock_d = 1'b1;
                    timer_d  = timer_q - TMR_W'(1);
                end
            end
            ST_FAIL: begin
                det_clr_d  = 1'b1;
                fail_cnt_d = fail_next;
                if (fail_next == FAIL_LIM) begin
                    locked_d = 1'b1;
                    timer_d  = T_LOCK;
                    state_d  = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    locked_d = 1'b1;
                    timer_d  = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CHECK);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            acc_cnt_q  <= '0;
            fail_cnt_q <= '0;
            first_q    <= 1'b1;
            det_s_q    <= 1'b0;
            det_a_q    <= 1'b0;
            det_clr_q  <= 1'b1;
            unlock_q   <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            acc_cnt_q  <= acc_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            first_q    <= first_d;
            det_s_q    <= det_s_d;
            det_a_q    <= det_a_d;
            det_clr_q  <= det_clr_d;
            unlock_q   <= unlock_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
        end
    end

    assign det_s    = det_s_q;
    assign det_a    = det_a_q;
    assign det_clr  = det_clr_q;
    assign unlock   = unlock_q;
    assign locked   = locked_q;
    assign fail_cnt = fail_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seqlock_ctrl.sv
// Directed bench for seqlock_ctrl with a behavioural colour-sequence detector
// (start, red, blue, green, red) attached.
module tb_seqlock_ctrl;

    localparam logic [2:0] C_R = 3'b100;
    localparam logic [2:0] C_G = 3'b010;
    localparam logic [2:0] C_B = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s = 1'b0;
    logic       a = 1'b0;
    logic       det_u;
    logic       det_s, det_a, det_clr, unlock, locked, busy;
    logic [1:0] fail_cnt;
    logic [2:0] col = 3'b000;

    int n_assert = 0;
    int n_fail   = 0;
    int n_det_s = 0, n_det_a = 0, n_det_clr = 0, n_unlock = 0, n_locked = 0;
    int base_s, base_a, base_clr, base_unl, base_lck;

    seqlock_ctrl #(
        .CODE_LEN(4), .TIMEOUT_CYC(20), .UNLOCK_CYC(4), .LOCKOUT_CYC(30), .MAX_FAIL(3)
    ) dut (
        .clk(clk), .rst(rst), .s(s), .a(a), .det_u(det_u),
        .det_s(det_s), .det_a(det_a), .det_clr(det_clr), .unlock(unlock),
        .locked(locked), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {D_WAIT, D_S0, D_R, D_RB, D_RBG, D_MATCH} dstate_t;
    dstate_t dst = D_WAIT;

    // Detector: registers its state on start/accept, clears synchronously.
    always @(posedge clk) begin
        if (det_clr) dst <= D_WAIT;
        else if (det_s) dst <= D_S0;
        else if (det_a) begin
            case (dst)
                D_S0:    dst <= (col == C_R) ? D_R   : D_WAIT;
                D_R:     dst <= (col == C_B) ? D_RB  : D_WAIT;
                D_RB:    dst <= (col == C_G) ? D_RBG : D_WAIT;
                D_RBG:   dst <= (col == C_R) ? D_MATCH : D_WAIT;
                default: dst <= D_WAIT;
            endcase
        end
    end
    assign det_u = (dst == D_MATCH);

    // Count high cycles of each output, sampled mid-cycle.
    always @(negedge clk) begin
        if (det_s)   n_det_s++;
        if (det_a)   n_det_a++;
        if (det_clr) n_det_clr++;
        if (unlock)  n_unlock++;
        if (locked)  n_locked++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic is_a, input logic [2:0] c);
        col = c;
        if (is_a) a = 1'b1; else s = 1'b1;
        tick(3);
        a = 1'b0;
        s = 1'b0;
        tick(3);
    endtask

    // Last accept of an attempt; returns during the CHECK cycle.
    task automatic last_accept(input logic [2:0] c);
        col = c;
        a = 1'b1;
        tick(3);
        a = 1'b0;
        tick(2);
    endtask

    task automatic attempt(input logic [2:0] c0, input logic [2:0] c1,
                           input logic [2:0] c2, input logic [2:0] c3);
        press(1'b0, 3'b000);
        press(1'b1, c0);
        press(1'b1, c1);
        press(1'b1, c2);
        last_accept(c3);
    endtask

    task automatic expect_unlock(input string tag);
        base_unl = n_unlock;
        base_clr = n_det_clr;
        check({tag, ".busy_check"}, busy, 1);
        tick(1);
        check({tag, ".unlock_rise"}, unlock, 1);
        check({tag, ".busy_low"}, busy, 0);
        check({tag, ".fail_cnt"}, fail_cnt, 0);
        tick(3);
        check({tag, ".unlock_held"}, unlock, 1);
        tick(1);
        check({tag, ".unlock_fall"}, unlock, 0);
        check({tag, ".det_clr_pulse"}, det_clr, 1);
        tick(1);
        check({tag, ".det_clr_end"}, det_clr, 0);
        check({tag, ".unlock_cycles"}, n_unlock - base_unl, 4);
        check({tag, ".det_clr_count"}, n_det_clr - base_clr, 1);
    endtask

    task automatic expect_fail(input string tag, input logic [1:0] exp_cnt, input logic exp_lock);
        check({tag, ".busy_check"}, busy, 1);
        tick(1);
        check({tag, ".no_unlock"}, unlock, 0);
        check({tag, ".det_clr_fail"}, det_clr, 0);
        tick(1);
        check({tag, ".det_clr_pulse"}, det_clr, 1);
        check({tag, ".fail_cnt"}, fail_cnt, exp_cnt);
        check({tag, ".locked"}, locked, exp_lock);
        check({tag, ".no_unlock2"}, unlock, 0);
        tick(1);
        check({tag, ".det_clr_end"}, det_clr, 0);
    endtask

    initial begin
        // Reset values
        tick(2);
        check("rst.det_clr", det_clr, 1);
        check("rst.det_s", det_s, 0);
        check("rst.det_a", det_a, 0);
        check("rst.unlock", unlock, 0);
        check("rst.locked", locked, 0);
        check("rst.fail_cnt", fail_cnt, 0);
        check("rst.busy", busy, 0);
        rst = 1'b1;
        tick(1);
        check("rst.det_clr_hold", det_clr, 1);
        tick(1);
        check("rst.det_clr_drop", det_clr, 0);

        // Accept in IDLE is ignored
        base_a = n_det_a;
        press(1'b1, C_R);
        tick(3);
        check("idle_a.det_a_count", n_det_a - base_a, 0);
        check("idle_a.busy", busy, 0);

        // Held accept during ARMED: one pulse, 3 cycles after the sampled edge
        press(1'b0, 3'b000);
        base_a = n_det_a;
        col = C_R;
        a = 1'b1;
        tick(3);
        check("held.det_a_early", det_a, 0);
        tick(1);
        check("held.det_a_pulse", det_a, 1);
        tick(1);
        check("held.det_a_end", det_a, 0);
        tick(95);
        a = 1'b0;
        tick(5);
        check("held.det_a_count", n_det_a - base_a, 1);
        check("held.fail_cnt", fail_cnt, 1);
        check("held.busy", busy, 0);

        // Correct code
        base_a = n_det_a;
        base_s = n_det_s;
        attempt(C_R, C_B, C_G, C_R);
        check("ok1.det_a_count", n_det_a - base_a, 4);
        check("ok1.det_s_count", n_det_s - base_s, 1);
        check("ok1.det_u", det_u, 1);
        expect_unlock("ok1");

        // Wrong colour
        attempt(C_R, C_G, C_G, C_R);
        check("bad1.det_u", det_u, 0);
        expect_fail("bad1", 2'd1, 1'b0);

        // Timeout after one accept
        press(1'b0, 3'b000);
        press(1'b1, C_R);
        check("tmo.busy_start", busy, 1);
        tick(17);
        check("tmo.busy_late", busy, 1);
        check("tmo.fail_cnt_before", fail_cnt, 1);
        tick(1);
        check("tmo.busy_fail", busy, 0);
        tick(1);
        check("tmo.fail_cnt", fail_cnt, 2);
        check("tmo.det_clr", det_clr, 1);
        tick(2);

        // Correct code clears the failure count
        attempt(C_R, C_B, C_G, C_R);
        expect_unlock("ok2");

        // Accept landing on the timer-expiry cycle is honoured
        press(1'b0, 3'b000);
        press(1'b1, C_R);
        tick(14);
        col = C_B;
        a = 1'b1;
        tick(3);
        a = 1'b0;
        tick(1);
        check("expiry.det_a", det_a, 1);
        check("expiry.busy", busy, 1);
        tick(1);
        check("expiry.busy_after", busy, 1);
        check("expiry.fail_cnt", fail_cnt, 0);
        tick(4);
        press(1'b1, C_G);
        last_accept(C_R);
        expect_unlock("expiry");

        // Three wrong attempts -> lockout
        attempt(C_G, C_B, C_G, C_R);
        expect_fail("lk1", 2'd1, 1'b0);
        attempt(C_R, C_R, C_G, C_R);
        expect_fail("lk2", 2'd2, 1'b0);
        base_lck = n_locked;
        attempt(C_R, C_B, C_B, C_R);
        expect_fail("lk3", 2'd3, 1'b1);
        base_s = n_det_s;
        base_a = n_det_a;
        press(1'b0, 3'b000);
        press(1'b1, C_R);
        check("lock.held", locked, 1);
        check("lock.det_s_ignored", n_det_s - base_s, 0);
        check("lock.det_a_ignored", n_det_a - base_a, 0);
        check("lock.busy", busy, 0);
        tick(16);
        check("lock.still", locked, 1);
        tick(1);
        check("lock.release", locked, 0);
        check("lock.fail_cnt_clr", fail_cnt, 0);
        check("lock.cycles", n_locked - base_lck, 30);
        attempt(C_R, C_B, C_G, C_R);
        expect_unlock("after_lock");

        // Reset mid-attempt
        attempt(C_B, C_B, C_G, C_R);
        expect_fail("pre_rst", 2'd1, 1'b0);
        press(1'b0, 3'b000);
        press(1'b1, C_R);
        press(1'b1, C_B);
        check("mid_rst.busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst.busy", busy, 0);
        check("mid_rst.fail_cnt", fail_cnt, 0);
        check("mid_rst.det_clr", det_clr, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("mid_rst.det_clr_hold", det_clr, 1);
        tick(1);
        check("mid_rst.det_clr_drop", det_clr, 0);
        attempt(C_R, C_B, C_G, C_R);
        expect_unlock("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
